// File: rtl/dwt_level3_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dwt_level3_stage
//  Description : Level-3 Haar stage of the ECG DWT chain. Pairs consecutive
//                level-2 approximation samples into cA_l3 = a0 + a1 and
//                cD_l3 = a0 - a1, buffers one frame of cD_l3 in a cleared-
//                on-reset store and holds off input once the frame is full.
//                Optional macro DWT_L3_PEAK_EN adds a per-frame |cD| peak
//                tracker (peak_mag / peak_idx).
//  Revision    : 1.0 - initial release
// ============================================================================
module dwt_level3_stage #(
  parameter int IN_W = 16,
  parameter int N3   = 64,
  parameter int AW   = 6
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   out_valid,
  output logic signed [IN_W:0]   cA_l3,
  output logic signed [IN_W:0]   cD_l3,
  output logic                   frame_done,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic signed [IN_W:0]   rd_data,
  output logic                   rd_valid
`ifdef DWT_L3_PEAK_EN
  ,
  output logic [IN_W:0]          peak_mag,
  output logic [AW-1:0]          peak_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t                 state;
  logic [AW-1:0]          cnt;
  logic signed [IN_W-1:0] a0;
  logic signed [IN_W:0]   store [N3];

  logic                   xfer;
  logic                   pair_done;
  logic                   last_pair;
  logic [IN_W:0]          a0_sx;
  logic [IN_W:0]          in_sx;
  logic [IN_W:0]          sum_w;
  logic [IN_W:0]          diff_w;
  logic                   rd_in_range;

  // Ready is a pure decode of the state register, so it drops the instant
  // reset is applied and never depends on in_valid.
  assign in_ready  = (state == EVEN) || (state == ODD);
  assign xfer      = in_valid && in_ready;

  // A transfer that coincides with start belongs to the aborted frame and
  // is therefore dropped.
  assign pair_done = (state == ODD) && xfer && !start;
  assign last_pair = (cnt == AW'(N3 - 1));

  // Sign-extend both operands by one bit so the sum/difference can never wrap.
  assign a0_sx  = {a0[IN_W-1], a0};
  assign in_sx  = {in_data[IN_W-1], in_data};
  assign sum_w  = a0_sx + in_sx;
  assign diff_w = a0_sx - in_sx;

  assign rd_in_range = ({1'b0, rd_addr} < (AW + 1)'(N3));

`ifdef DWT_L3_PEAK_EN
  logic [IN_W:0] diff_abs;

  // Magnitude in IN_W+1 unsigned bits; -2**IN_W maps to 2**IN_W exactly.
  assign diff_abs = diff_w[IN_W] ? (~diff_w + 1'b1) : diff_w;
`endif

  // Frame sequencer: pairs samples, registers coefficients and pulses.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      cnt        <= '0;
      a0         <= '0;
      out_valid  <= 1'b0;
      cA_l3      <= '0;
      cD_l3      <= '0;
      frame_done <= 1'b0;
`ifdef DWT_L3_PEAK_EN
      peak_mag   <= '0;
      peak_idx   <= '0;
`endif
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (start) begin
        // New frame (or abort of the current one): counters restart and
        // any half-formed pair is discarded. The store is left untouched.
        state    <= EVEN;
        cnt      <= '0;
        a0       <= '0;
`ifdef DWT_L3_PEAK_EN
        peak_mag <= '0;
        peak_idx <= '0;
`endif
      end else begin
        case (state)
          IDLE: state <= IDLE;
          EVEN: begin
            if (xfer) begin
              a0    <= in_data;
              state <= ODD;
            end
          end
          ODD: begin
            if (pair_done) begin
              cA_l3     <= sum_w;
              cD_l3     <= diff_w;
              out_valid <= 1'b1;
              cnt       <= cnt + 1'b1;
`ifdef DWT_L3_PEAK_EN
              // Strict compare keeps the earliest index on ties.
              if (diff_abs > peak_mag) begin
                peak_mag <= diff_abs;
                peak_idx <= cnt;
              end
`endif
              if (last_pair) begin
                frame_done <= 1'b1;
                state      <= FULL;
              end else begin
                state <= EVEN;
              end
            end
          end
          FULL:    state <= FULL;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Detail store: fully cleared on reset, one write per completed pair.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < N3; i++) begin
        store[i] <= '0;
      end
    end else if (pair_done) begin
      store[cnt] <= diff_w;
    end
  end

  // Read port: registered data, old value on same-cycle write, zero when
  // the address lies beyond the frame depth.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_range ? store[rd_addr] : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dwt_level3_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dwt_level3_stage
//  Description : Self-checking bench for dwt_level3_stage: table-driven pair
//                vectors plus hand-written frame, abort, reset and (when
//                DWT_L3_PEAK_EN is defined) peak-tracker sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dwt_level3_stage;

  localparam int IN_W = 16;
  localparam int N3   = 64;
  localparam int AW   = 6;

  logic                   clk = 1'b0;
  logic                   nReset = 1'b0;
  logic                   start = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [IN_W-1:0] in_data = '0;
  logic                   out_valid;
  logic signed [IN_W:0]   cA_l3;
  logic signed [IN_W:0]   cD_l3;
  logic                   frame_done;
  logic                   rd_en = 1'b0;
  logic [AW-1:0]          rd_addr = '0;
  logic signed [IN_W:0]   rd_data;
  logic                   rd_valid;
`ifdef DWT_L3_PEAK_EN
  logic [IN_W:0]          peak_mag;
  logic [AW-1:0]          peak_idx;
`endif

  int total = 0;
  int bad   = 0;
  int ov_cnt = 0;
  int fd_cnt = 0;

  typedef struct {
    logic signed [IN_W-1:0] a0;
    logic signed [IN_W-1:0] a1;
    logic signed [IN_W:0]   ca;
    logic signed [IN_W:0]   cd;
  } vec_t;

  vec_t vecs [6];
  logic signed [IN_W:0] model [N3];

  dwt_level3_stage #(.IN_W(IN_W), .N3(N3), .AW(AW)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .cA_l3      (cA_l3),
    .cD_l3      (cD_l3),
    .frame_done (frame_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
`ifdef DWT_L3_PEAK_EN
    ,
    .peak_mag   (peak_mag),
    .peak_idx   (peak_idx)
`endif
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (out_valid)  ov_cnt++;
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one sample and hold it until accepted (bounded).
  task automatic send(input logic signed [IN_W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd(input int addr, input longint exp, input string nm);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    tick();
    rd_en = 1'b0;
    check({nm, "_rdv"}, longint'(rd_valid), 1);
    check(nm, longint'(rd_data), exp);
  endtask

  initial begin
    logic signed [IN_W-1:0] x0, x1;
    logic signed [IN_W:0]   ecd;

    vecs[0] = '{a0: 16'sd10,     a1: 16'sd4,      ca: 17'sd14,     cd: 17'sd6};
    vecs[1] = '{a0: -16'sd32768, a1: -16'sd32768, ca: -17'sd65536, cd: 17'sd0};
    vecs[2] = '{a0: 16'sd32767,  a1: -16'sd32768, ca: -17'sd1,     cd: 17'sd65535};
    vecs[3] = '{a0: -16'sd32768, a1: 16'sd32767,  ca: -17'sd1,     cd: -17'sd65535};
    vecs[4] = '{a0: -16'sd5,     a1: 16'sd7,      ca: 17'sd2,      cd: -17'sd12};
    vecs[5] = '{a0: 16'sd0,      a1: 16'sd0,      ca: 17'sd0,      cd: 17'sd0};

    // ---------------- reset state ----------------
    #12;
    check("rst_in_ready",   longint'(in_ready), 0);
    check("rst_out_valid",  longint'(out_valid), 0);
    check("rst_cA",         longint'(cA_l3), 0);
    check("rst_cD",         longint'(cD_l3), 0);
    check("rst_frame_done", longint'(frame_done), 0);
    check("rst_rd_valid",   longint'(rd_valid), 0);
`ifdef DWT_L3_PEAK_EN
    check("rst_peak_mag", longint'(peak_mag), 0);
    check("rst_peak_idx", longint'(peak_idx), 0);
`endif
    tick();
    nReset = 1'b1;
    tick();
    tick();
    check("idle_in_ready", longint'(in_ready), 0);

    // ---------------- table-driven pairs ----------------
    pulse_start();
    check("even_in_ready", longint'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a0);
      check($sformatf("v%0d_no_ov_mid", i), longint'(out_valid), 0);
      send(vecs[i].a1);
      check($sformatf("v%0d_ov", i), longint'(out_valid), 1);
      check($sformatf("v%0d_cA", i), longint'(cA_l3), longint'(vecs[i].ca));
      check($sformatf("v%0d_cD", i), longint'(cD_l3), longint'(vecs[i].cd));
      tick();
      check($sformatf("v%0d_ov_pulse", i), longint'(out_valid), 0);
    end
    for (int i = 0; i < 6; i++) begin
      rd(i, longint'(vecs[i].cd), $sformatf("v%0d_store", i));
    end

    // ---------------- full frame with random gaps ----------------
    pulse_start();
    ov_cnt = 0;
    fd_cnt = 0;
    for (int p = 0; p < N3; p++) begin
      x0  = IN_W'($urandom);
      x1  = IN_W'($urandom);
      ecd = {x0[IN_W-1], x0} - {x1[IN_W-1], x1};
      model[p] = ecd;
      repeat ($urandom_range(0, 2)) tick();
      send(x0);
      repeat ($urandom_range(0, 2)) tick();
      send(x1);
      check($sformatf("f%0d_ov", p), longint'(out_valid), 1);
      check($sformatf("f%0d_cD", p), longint'(cD_l3), longint'(ecd));
      check($sformatf("f%0d_fd", p), longint'(frame_done), (p == N3 - 1) ? 1 : 0);
    end
    check("full_in_ready", longint'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 16'sd123;
    repeat (6) tick();
    in_valid = 1'b0;
    check("full_in_ready_hold", longint'(in_ready), 0);
    check("frame_ov_count", longint'(ov_cnt), N3);
    check("frame_fd_count", longint'(fd_cnt), 1);
    for (int i = 0; i < N3; i++) begin
      rd(i, longint'(model[i]), $sformatf("frame_store%0d", i));
    end

    // ---------------- mid-frame abort ----------------
    pulse_start();
    send(16'sd3);
    send(16'sd8);
    check("abort_first_cD", longint'(cD_l3), -5);
    send(16'sd7);
    pulse_start();
    send(16'sd2);
    check("abort_no_ov", longint'(out_valid), 0);
    send(16'sd1);
    check("abort_ov", longint'(out_valid), 1);
    check("abort_cA", longint'(cA_l3), 3);
    check("abort_cD", longint'(cD_l3), 1);
    rd(0, 1, "abort_store0");
    rd(1, longint'(model[1]), "abort_stale1");

    // ---------------- reset while in ODD ----------------
    send(16'sd5);
    check("odd_in_ready", longint'(in_ready), 1);
    #2;
    nReset = 1'b0;
    #1;
    check("arst_in_ready",  longint'(in_ready), 0);
    check("arst_out_valid", longint'(out_valid), 0);
    check("arst_cA",        longint'(cA_l3), 0);
    check("arst_cD",        longint'(cD_l3), 0);
    check("arst_fd",        longint'(frame_done), 0);
    tick();
    nReset = 1'b1;
    ov_cnt = 0;
    in_valid = 1'b1;
    in_data  = 16'sd9;
    repeat (4) tick();
    in_valid = 1'b0;
    check("arst_idle_ready", longint'(in_ready), 0);
    check("arst_no_ov", longint'(ov_cnt), 0);
    rd(0, 0, "arst_store0");
    rd(1, 0, "arst_store1");
    pulse_start();
    send(16'sd6);
    send(16'sd2);
    check("post_rst_cA", longint'(cA_l3), 8);
    check("post_rst_cD", longint'(cD_l3), 4);

`ifdef DWT_L3_PEAK_EN
    // ---------------- peak tracker ----------------
    pulse_start();
    check("pk_clr_mag", longint'(peak_mag), 0);
    check("pk_clr_idx", longint'(peak_idx), 0);
    send(16'sd5); send(16'sd0);
    send(16'sd0); send(16'sd9);
    send(16'sd9); send(16'sd0);
    send(16'sd3); send(16'sd0);
    for (int p = 4; p < N3; p++) begin
      send(16'sd0);
      send(16'sd0);
    end
    check("pk_fd", longint'(frame_done), 1);
    check("pk_mag", longint'(peak_mag), 9);
    check("pk_idx", longint'(peak_idx), 1);
    pulse_start();
    check("pk_restart_mag", longint'(peak_mag), 0);
    check("pk_restart_idx", longint'(peak_idx), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
